permutator_pipe: RTL and testbench

//  Pipelined, self-routing N-lane butterfly permutator; successor to the combinational slice network.

---
 rtl/permutator_pipe.sv | 135 +++++++++++++
 tb/tb_permutator_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permutator_pipe.sv
// Pipelined self-routing butterfly permutator; LOG2N stages, losing word of a conflict dropped.
// Latency LOG2N cycles; one beat/cycle. Global stall: every stage holds when !out_ready & out_valid.
// Optional saturating drop counter enabled by PERMUTATOR_PIPE_CNT_EN.
module permutator_pipe #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 32,
    localparam int N     = 1 << LOG2N
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_lane_vld,
    input  logic [N*DATA_W-1:0]   in_dat,
    input  logic [N*LOG2N-1:0]    in_adr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_lane_vld,
    output logic [N*DATA_W-1:0]   out_dat,
    output logic [N*LOG2N-1:0]    out_src,
    output logic                  out_drop,
    output logic [15:0]           conflict_cnt
);

    logic adv;

    // Index 0 is the input port, index j+1 is the register of stage j.
    logic                         p_vld  [LOG2N+1];
    logic                         p_drop [LOG2N+1];
    logic [N-1:0]                 p_lv   [LOG2N+1];
    logic [N-1:0][DATA_W-1:0]     p_dat  [LOG2N+1];
    logic [N-1:0][LOG2N-1:0]      p_adr  [LOG2N+1];
    logic [N-1:0][LOG2N-1:0]      p_src  [LOG2N+1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // A bubble beat carries no words, so it cannot raise a conflict downstream.
    assign p_vld[0]  = in_valid;
    assign p_drop[0] = 1'b0;
    assign p_lv[0]   = in_lane_vld & {N{in_valid}};
    assign p_dat[0]  = in_dat;
    assign p_adr[0]  = in_adr;

    for (genvar g = 0; g < N; g++) begin : g_src_init
        assign p_src[0][g] = LOG2N'(g);
    end

    for (genvar j = 0; j < LOG2N; j++) begin : g_stage
        localparam int D   = N >> (j + 1);
        localparam int BIT = LOG2N - 1 - j;

        logic [N-1:0]             conf;
        logic [N-1:0]             lv_d,  lv_q;
        logic [N-1:0][DATA_W-1:0] dat_d, dat_q;
        logic [N-1:0][LOG2N-1:0]  adr_d, adr_q;
        logic [N-1:0][LOG2N-1:0]  src_d, src_q;
        logic                     drop_d, drop_q, vld_q;

        for (genvar k = 0; k < N; k++) begin : g_lane
            localparam int   P  = k ^ D;
            localparam logic KB = ((k & D) != 0);

            logic own_hit, par_hit, take_par;

            // Output lane k accepts whichever of the pair steers its routing bit to k's side.
            assign own_hit  = p_lv[j][k] && (p_adr[j][k][BIT] == KB);
            assign par_hit  = p_lv[j][P] && (p_adr[j][P][BIT] == KB);
            assign take_par = par_hit && (!own_hit || (p_src[j][P] < p_src[j][k]));
            assign conf[k]  = own_hit && par_hit;

            assign lv_d[k]  = own_hit || par_hit;
            assign dat_d[k] = take_par ? p_dat[j][P] : (own_hit ? p_dat[j][k] : '0);
            assign adr_d[k] = take_par ? p_adr[j][P] : (own_hit ? p_adr[j][k] : '0);
            assign src_d[k] = take_par ? p_src[j][P] : (own_hit ? p_src[j][k] : '0);
        end

        assign drop_d = p_drop[j] || (|conf);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                drop_q <= 1'b0;
                lv_q   <= '0;
                dat_q  <= '0;
                adr_q  <= '0;
                src_q  <= '0;
            end else if (adv) begin
                vld_q  <= p_vld[j];
                drop_q <= drop_d;
                lv_q   <= lv_d;
                dat_q  <= dat_d;
                adr_q  <= adr_d;
                src_q  <= src_d;
            end
        end

        assign p_vld[j+1]  = vld_q;
        assign p_drop[j+1] = drop_q;
        assign p_lv[j+1]   = lv_q;
        assign p_dat[j+1]  = dat_q;
        assign p_adr[j+1]  = adr_q;
        assign p_src[j+1]  = src_q;
    end

    assign out_valid    = p_vld[LOG2N];
    assign out_drop     = p_drop[LOG2N];
    assign out_lane_vld = p_lv[LOG2N];
    assign out_dat      = p_dat[LOG2N];
    assign out_src      = p_src[LOG2N];

`ifdef PERMUTATOR_PIPE_CNT_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && out_drop && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_permutator_pipe.sv
// Scoreboard bench for permutator_pipe (LOG2N=3, DATA_W=16) with directed vectors.
module tb_permutator_pipe;
    localparam int LOG2N  = 3;
    localparam int DATA_W = 16;
    localparam int N      = 8;
`ifdef PERMUTATOR_PIPE_CNT_EN
    localparam int CNT1 = 1;
`else
    localparam int CNT1 = 0;
`endif

    typedef struct {
        logic [7:0]       lv;
        logic [7:0][15:0] dat;
        logic [7:0][2:0]  src;
        logic             drop;
        int               acc;
        bit               lat;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_lane_vld;
    logic [N*DATA_W-1:0] in_dat;
    logic [N*LOG2N-1:0]  in_adr;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_lane_vld;
    logic [N*DATA_W-1:0] out_dat;
    logic [N*LOG2N-1:0]  out_src;
    logic                out_drop;
    logic [15:0]         conflict_cnt;

    permutator_pipe #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_vld  (in_lane_vld),
        .in_dat       (in_dat),
        .in_adr       (in_adr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_vld (out_lane_vld),
        .out_dat      (out_dat),
        .out_src      (out_src),
        .out_drop     (out_drop),
        .conflict_cnt (conflict_cnt)
    );

    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.lv   = '0;
        e.dat  = '0;
        e.src  = '0;
        e.drop = 1'b0;
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // Monitor: pops one expected beat per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=out_valid required=no beat");
                end else begin
                    e = sb.pop_front();
                    chk("out_lane_vld", out_lane_vld, e.lv);
                    chk("out_dat", out_dat, e.dat);
                    chk("out_src", out_src, e.src);
                    chk("out_drop", out_drop, e.drop);
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    task automatic send(input logic [7:0] lv, input logic [7:0][15:0] d,
                        input logic [7:0][2:0] a, input exp_t e);
        int g;
        @(negedge clk);
        in_valid    = 1'b1;
        in_lane_vld = lv;
        in_dat      = d;
        in_adr      = a;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready 0 required=1");
        end else begin
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0][15:0] d;
        logic [7:0][2:0]  a;
        logic [127:0]     snap_d;
        logic [23:0]      snap_s;
        logic [7:0]       snap_lv;
        exp_t             e;
        int               t;
        int               b;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_lane_vld = '0;
        in_dat = '0;
        in_adr = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lane_vld", out_lane_vld, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_drop", out_drop, 0);
        chk("rst_conflict_cnt", conflict_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Identity, with latency check.
        e = blank();
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'hA000 + 16'(i);
            a[i] = 3'(i);
            e.dat[i] = 16'hA000 + 16'(i);
            e.src[i] = 3'(i);
        end
        e.lv = 8'hFF;
        e.lat = 1'b1;
        send(8'hFF, d, a, e);
        drain();

        // Reversal.
        e = blank();
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'(i);
            a[i] = 3'(7 - i);
            e.dat[i] = 16'(7 - i);
            e.src[i] = 3'(7 - i);
        end
        e.lv = 8'hFF;
        send(8'hFF, d, a, e);
        drain();

        // All lanes to lane 0: only source 0 survives.
        e = blank();
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'h10 + 16'(i);
            a[i] = 3'd0;
        end
        e.lv = 8'h01;
        e.dat[0] = 16'h10;
        e.drop = 1'b1;
        send(8'hFF, d, a, e);
        drain();
        chk("conflict_cnt_after_all_to_zero", conflict_cnt, CNT1);

        // Valid beat with no words.
        e = blank();
        send(8'h00, d, a, e);
        drain();

        // Sparse: masked lanes carry garbage that must not interfere.
        e = blank();
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'hDEAD;
            a[i] = 3'd6;
        end
        d[0] = 16'h5550;
        d[2] = 16'h5552;
        a[2] = 3'd3;
        e.lv = 8'b0100_1000;
        e.dat[6] = 16'h5550;
        e.dat[3] = 16'h5552;
        e.src[6] = 3'd0;
        e.src[3] = 3'd2;
        send(8'b0000_0101, d, a, e);
        drain();

        // Eight back-to-back XOR permutations, out_ready low on cycles 4..6.
        t = 0;
        b = 0;
        snap_d = '0;
        snap_s = '0;
        snap_lv = '0;
        while (b < 8 && t < 100) begin
            @(negedge clk);
            out_ready = !(t >= 4 && t <= 6);
            for (int i = 0; i < 8; i++) begin
                d[i] = 16'hB000 + 16'(b * 16 + i);
                a[i] = 3'(i ^ b);
            end
            in_valid = 1'b1;
            in_lane_vld = 8'hFF;
            in_dat = d;
            in_adr = a;
            #1;
            if (t >= 4 && t <= 6) begin
                chk("stall_in_ready", in_ready, 0);
                if (t == 4) begin
                    snap_d = out_dat;
                    snap_s = out_src;
                    snap_lv = out_lane_vld;
                end else begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_dat", out_dat, snap_d);
                    chk("stall_hold_src", out_src, snap_s);
                    chk("stall_hold_lv", out_lane_vld, snap_lv);
                end
            end
            if (in_ready) begin
                e = blank();
                e.lv = 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    e.dat[k] = 16'hB000 + 16'(b * 16 + (k ^ b));
                    e.src[k] = 3'(k ^ b);
                end
                sb.push_back(e);
                b++;
            end
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight.
        for (int n = 0; n < 3; n++) begin
            e = blank();
            e.lv = 8'hFF;
            for (int i = 0; i < 8; i++) begin
                d[i] = 16'hC000 + 16'(n * 16 + i);
                a[i] = 3'(i);
                e.dat[i] = 16'hC000 + 16'(n * 16 + i);
                e.src[i] = 3'(i);
            end
            send(8'hFF, d, a, e);
        end
        @(negedge clk);
        chk("inflight_out_valid", out_valid, 1);
        chk("pre_reset_conflict_cnt", conflict_cnt, CNT1);
        reset_n = 1'b0;
        sb.delete();
        #2;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_lane_vld", out_lane_vld, 0);
        chk("mid_rst_out_dat", out_dat, 0);
        chk("mid_rst_conflict_cnt", conflict_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        e = blank();
        e.lv = 8'hFF;
        e.lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'hD000 + 16'(i);
            a[i] = 3'(i ^ 3);
            e.dat[i] = 16'hD000 + 16'(i ^ 3);
            e.src[i] = 3'(i ^ 3);
        end
        send(8'hFF, d, a, e);
        drain();
        chk("post_rst_conflict_cnt", conflict_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
